// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TX FIFO, transmit sequencer, RX capture,
// status/interrupt flags and CPU interrupt request.
module uart_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR     = 32'h40000018,
  parameter int unsigned TX_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        tx_status,
  output logic [7:0]  tx_data,
  output logic        tx_start
);

  localparam int unsigned PTR_W = $clog2(TX_FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] TXD_ADDR = BASE_ADDR;
  localparam logic [31:0] RXD_ADDR = BASE_ADDR + 32'd4;
  localparam logic [31:0] CON_ADDR = BASE_ADDR + 32'd8;
  localparam logic [3:0]  TIMEOUT_LAST = 4'd14;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic [3:0]        to_cnt_q;
  logic [7:0]        fifo_q [TX_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        rxd_q;
  logic              tx_ie_q, rx_ie_q, tx_flag_q, rx_flag_q, tx_ovf_q, rx_ovr_q;
  logic              tx_ie_d, rx_ie_d, tx_flag_d, rx_flag_d, tx_ovf_d, rx_ovr_d;

  logic txd_wr, con_wr, con_rd;
  logic fifo_full, fifo_empty, push, pop, drop;
  logic timeout, tx_done_set, tx_busy;
  logic unused_wdata;

  assign unused_wdata = ^{wdata[31:7], wdata[4:2]};

  // Bus decode and FIFO handshake
  assign txd_wr      = wr_en && (addr == TXD_ADDR);
  assign con_wr      = wr_en && (addr == CON_ADDR);
  assign con_rd      = rd_en && (addr == CON_ADDR);
  assign fifo_full   = (count_q == CNT_W'(TX_FIFO_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign pop         = (state_q == S_ISSUE);
  assign push        = txd_wr && (!fifo_full || pop);
  assign drop        = txd_wr && fifo_full && !pop;
  assign timeout     = (state_q == S_WAIT_BUSY) && tx_status && (to_cnt_q == TIMEOUT_LAST);
  assign tx_done_set = ((state_q == S_WAIT_DONE) && tx_status) || timeout;
  assign tx_busy     = (state_q != S_IDLE) || !fifo_empty;

  // Read mux: combinational, zero when not selected
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      if (addr == RXD_ADDR) begin
        rdata = {24'd0, rxd_q};
      end else if (addr == CON_ADDR) begin
        rdata = {25'd0, rx_ovr_q, tx_ovf_q, tx_busy, rx_flag_q, tx_flag_q, rx_ie_q, tx_ie_q};
      end
    end
  end

  // FIFO occupancy next state
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control/status next state: set events win over read-clear and W1C
  always_comb begin
    tx_ie_d   = tx_ie_q;
    rx_ie_d   = rx_ie_q;
    tx_flag_d = tx_flag_q;
    rx_flag_d = rx_flag_q;
    tx_ovf_d  = tx_ovf_q;
    rx_ovr_d  = rx_ovr_q;
    if (con_wr) begin
      tx_ie_d = wdata[0];
      rx_ie_d = wdata[1];
      if (wdata[5]) tx_ovf_d = 1'b0;
      if (wdata[6]) rx_ovr_d = 1'b0;
    end
    if (con_rd) begin
      tx_flag_d = 1'b0;
      rx_flag_d = 1'b0;
    end
    if (tx_done_set) tx_flag_d = 1'b1;
    if (rx_done)     rx_flag_d = 1'b1;
    if (drop)        tx_ovf_d  = 1'b1;
    if (rx_done && rx_flag_q && !con_rd) rx_ovr_d = 1'b1;
  end

  // Status registers, RX byte and interrupt request
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ie_q   <= 1'b0;
      rx_ie_q   <= 1'b0;
      tx_flag_q <= 1'b0;
      rx_flag_q <= 1'b0;
      tx_ovf_q  <= 1'b0;
      rx_ovr_q  <= 1'b0;
      rxd_q     <= '0;
      irq       <= 1'b0;
    end else begin
      tx_ie_q   <= tx_ie_d;
      rx_ie_q   <= rx_ie_d;
      tx_flag_q <= tx_flag_d;
      rx_flag_q <= rx_flag_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovr_q  <= rx_ovr_d;
      if (rx_done) rxd_q <= rx_data;
      irq <= (tx_ie_d & tx_flag_d) | (rx_ie_d & rx_flag_d);
    end
  end

  // TX FIFO pointers and occupancy; reset flushes the queue
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= wdata[7:0];
  end

  // Transmit sequencer: one byte in flight, tx_start asserted during ISSUE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      to_cnt_q <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty && tx_status) begin
            state_q  <= S_ISSUE;
            tx_start <= 1'b1;
            tx_data  <= fifo_q[rd_ptr_q];
          end
        end
        S_ISSUE: begin
          state_q  <= S_WAIT_BUSY;
          to_cnt_q <= '0;
        end
        S_WAIT_BUSY: begin
          if (!tx_status) begin
            state_q <= S_WAIT_DONE;
          end else if (to_cnt_q == TIMEOUT_LAST) begin
            state_q <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 4'd1;
          end
        end
        S_WAIT_DONE: begin
          if (tx_status) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
Memory-mapped UART controller between the pipelined CPU's MEM-stage peripheral bus and the existing byte-level UART receiver/transmitter cores (9600 baud at 50 MHz).
- Buffers outgoing bytes in a small TX FIFO and sequences the transmitter one byte at a time.
- Captures received bytes and maintains status/interrupt flags.
- Drives the CPU interrupt request line.

Parameters:
- BASE_ADDR, 32'h40000018, address of TXD; RXD at BASE_ADDR+4, UART_CON at BASE_ADDR+8
- TX_FIFO_DEPTH, 4, TX FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- addr  input  32  CPU bus byte address
- rd_en  input  1  CPU bus read strobe
- wr_en  input  1  CPU bus write strobe
- wdata  input  32  CPU bus write data
- rdata  output  32  CPU bus read data (combinational)
- irq  output  1  registered interrupt request
- rx_data  input  8  byte from UART receiver, valid when rx_done=1
- rx_done  input  1  one-cycle pulse: new byte received
- tx_status  input  1  1 = transmitter idle/ready, 0 = shifting
- tx_data  output  8  byte to UART transmitter
- tx_start  output  1  one-cycle pulse: start transmission of tx_data

Behaviour:
- Reset values: rdata=0 (bus idle), irq=0, tx_start=0, tx_data=0, FIFO empty, RXD=0, UART_CON=0, FSM=IDLE.
- Register map: TXD write-only (read returns 0); RXD read-only; UART_CON read/write. Any other address: rdata=0, writes ignored.
- rdata = selected register zero-extended when rd_en=1 and address matches, else 0. Same-cycle combinational, no wait states.
- UART_CON bits:
  - [0] TX irq enable (RW)
  - [1] RX irq enable (RW)
  - [2] TX done, sticky; cleared by CON read
  - [3] RX done, sticky; cleared by CON read
  - [4] TX busy (RO) = FSM≠IDLE or FIFO non-empty
  - [5] TX overflow, sticky, W1C
  - [6] RX overrun, sticky, W1C
  - [31:7] read 0
- Read-to-clear: the rdata for a CON read shows pre-clear values; bits [3:2] clear at that clock edge.
- Set/clear priority: if a set event and a clear (read or W1C) hit the same bit in the same cycle, set wins.
- CON write: bits [1:0] load wdata[1:0]; wdata[5]=1 clears [5]; wdata[6]=1 clears [6]; other wdata bits ignored.
- TXD write (wr_en & addr==BASE_ADDR):
  - FIFO not full: push wdata[7:0].
  - FIFO full: byte dropped, CON[5] set.
  - Push into a FIFO that is popped in the same cycle is legal; count unchanged.
- RX path: on rx_done, RXD<=rx_data and CON[3] is set.
  - If CON[3] is already 1 and not being cleared in that cycle, CON[6] is also set.
  - RXD read has no side effect.
- TX FSM:
  - IDLE: FIFO non-empty and tx_status=1 → ISSUE.
  - ISSUE (1 cycle): tx_data<=head, tx_start=1, pop → WAIT_BUSY.
  - WAIT_BUSY: tx_status=0 → WAIT_DONE. Also return to IDLE with CON[2] set after 15 cycles without busy (timeout guard).
  - WAIT_DONE: tx_status=1 → set CON[2], go to IDLE.
  - tx_data holds the last value outside ISSUE. Bytes go out in strict FIFO order, and at most one is in flight.
- irq: registered, irq <= (CON[0]&CON[2]) | (CON[1]&CON[3]), using next-state CON values. Falls one cycle after the causing flag clears.
- Reset mid-transmission aborts the FSM and flushes the FIFO. No tx_start pulse is issued in the reset cycle.

Test Plan:
1. Reset, then read CON → rdata=0, irq=0, tx_start=0, FIFO empty.
2. Write TXD=0x55 with tx_status=1. tx_start pulses exactly one cycle, 2 cycles after the write, with tx_data=0x55. Model drops tx_status for 10 cycles → CON[2]=1 after tx_status returns to 1. With CON=0x1, irq=1 the following cycle. A CON read returns 0x05, and irq=0 one cycle later.
3. Five back-to-back TXD writes 0x01..0x05 while tx_status=0:
   - 0x05 dropped, CON[5]=1, CON[4]=1.
   - After tx_status rises, 0x01..0x04 go out in order, one tx_start per completed byte.
   - Writing CON=0x20 clears bit 5.
4. rx_done with rx_data=0x38:
   - RXD read returns 0x38, CON[3]=1.
   - A second rx_done with 0x49 before the CON read → RXD=0x49, CON[6]=1.
   - CON read in the same cycle as an rx_done leaves CON[3]=1.
5. Assert reset while in WAIT_DONE with 2 bytes queued → all outputs return to reset values. No tx_start occurs after reset deasserts until a new TXD write.
6. Hold tx_status=1 constantly after ISSUE → timeout returns the FSM to IDLE after 15 cycles, sets CON[2], and the next queued byte issues.
